// File: rtl/program_loader.sv
// program_loader: boot-time loader feeding cpuCore's debug instruction-write port.
// Takes a framed byte stream (A5, N, N*4 little-endian data bytes), writes each
// assembled word to instruction memory, and holds the core in reset until the
// whole image is in place.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte before the core is released.
module program_loader #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] BASE_ADDR      = '0,
  parameter int              TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_RUN, S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [1:0]      byte_cnt;
  logic [7:0]      words_left;
  logic [23:0]     shift;      // first three bytes of the word in flight
  logic [XLEN-1:0] waddr;      // address the next completed word goes to
  logic            accept;
  logic            timed;
  logic            tmo_hit;
  logic            is_a5;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  // WRITE is the only cycle that cannot take a byte; the sender holds it.
  assign rx_ready = (state != S_WRITE);
  assign accept   = rx_valid && rx_ready;
  assign is_a5    = (rx_data == 8'hA5);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // States in which the inter-byte idle timer runs.
  always_comb begin
    timed = 1'b0;
    case (state)
      S_COUNT, S_DATA: timed = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:         timed = 1'b1;
`endif
      default:         timed = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_a5) state_nxt = S_COUNT;
      S_COUNT: begin
        if (accept)       state_nxt = (rx_data == 8'd0) ? S_ERROR : S_DATA;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_DATA: begin
        if (accept) begin
          if (byte_cnt == 2'd3) state_nxt = S_WRITE;
        end else if (tmo_hit) begin
          state_nxt = S_ERROR;
        end
      end
      S_WRITE: begin
        if (words_left != 8'd1) state_nxt = S_DATA;
`ifdef LOADER_CHECKSUM_EN
        else                    state_nxt = S_CHECK;
`else
        else                    state_nxt = S_RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept)       state_nxt = (rx_data == csum) ? S_RUN : S_ERROR;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
`endif
      S_RUN:   if (accept && is_a5) state_nxt = S_COUNT;
      S_ERROR: if (accept && is_a5) state_nxt = S_COUNT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath, counters and registered status outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt    <= '0;
      byte_cnt   <= '0;
      words_left <= '0;
      shift      <= '0;
      waddr      <= BASE_ADDR;
      dbg_wr_en  <= 1'b0;
      dbg_addr   <= BASE_ADDR;
      dbg_instr  <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      tmo_cnt <= (timed && !accept) ? tmo_cnt + TW'(1) : '0;

      if (state == S_COUNT && accept) begin
        words_left <= rx_data;
        byte_cnt   <= '0;
        waddr      <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end

      if (state == S_DATA && accept) begin
        shift    <= {rx_data, shift[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ rx_data;
`endif
        if (byte_cnt == 2'd3) begin
          dbg_instr <= XLEN'({rx_data, shift});
          dbg_addr  <= waddr;
          waddr     <= waddr + XLEN'(4);
        end
      end

      if (state == S_WRITE) words_left <= words_left - 8'd1;

      // A timeout drops any partially assembled word.
      if (state_nxt == S_ERROR) byte_cnt <= '0;

      dbg_wr_en <= (state_nxt == S_WRITE);
      core_rst  <= (state_nxt != S_RUN);
      done      <= (state_nxt == S_RUN);
      error     <= (state_nxt == S_ERROR);
      busy      <= (state_nxt == S_COUNT) || (state_nxt == S_DATA) ||
`ifdef LOADER_CHECKSUM_EN
                   (state_nxt == S_CHECK) ||
`endif
                   (state_nxt == S_WRITE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed tests for program_loader with a short timeout.
module tb_program_loader;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, dbg_wr_en, core_rst, busy, done, error;
  logic [31:0] dbg_addr, dbg_instr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];
  int          s_rdy_bad = 0;

  logic [7:0]  img [0:17] = '{8'hA5, 8'h04,
                              8'h13, 8'h81, 8'hC0, 8'h00, 8'h37, 8'h20, 8'h02, 8'h00,
                              8'hB3, 8'h51, 8'h21, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
  logic [31:0] img_words [0:3] = '{32'h00C08113, 32'h00022037, 32'h002151B3, 32'h00200093};

  program_loader #(.XLEN(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // cycle counter and write-strobe recorder
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dbg_wr_en === 1'b1) begin
      s_addr.push_back(dbg_addr);
      s_data.push_back(dbg_instr);
      s_cyc.push_back(cyc);
      if (rx_ready !== 1'b0) s_rdy_bad++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] img_csum();
    logic [7:0] c = 8'h00;
    for (int i = 2; i < 18; i++) c ^= img[i];
    return c;
  endfunction

  function automatic logic [7:0] word_csum(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++; failures++;
      $display("FAIL send_byte: rx_ready stuck low, byte %h not accepted", b);
    end
    @(negedge clk);
  endtask

  task automatic send_image();
    for (int i = 0; i < 18; i++) send_byte(img[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(img_csum());
`endif
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (core_rst !== 1'b1)    begin failures++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++; if (dbg_wr_en !== 1'b0)   begin failures++; $display("FAIL reset_wr_en: got %b want 0", dbg_wr_en); end
    checks++; if (dbg_addr !== 32'h0)   begin failures++; $display("FAIL reset_addr: got %h want 0", dbg_addr); end
    checks++; if (dbg_instr !== 32'h0)  begin failures++; $display("FAIL reset_instr: got %h want 0", dbg_instr); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
    checks++; if (rx_ready !== 1'b1)    begin failures++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    send_image();
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_addr.size() != 4) begin failures++; $display("FAIL basic_strobes: got %0d want 4", s_addr.size()); end
    for (int i = 0; i < 4 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== 32'(4 * i) || s_data[i] !== img_words[i]) begin
        failures++;
        $display("FAIL basic_word%0d: got %h@%h want %h@%h", i, s_data[i], s_addr[i], img_words[i], 32'(4 * i));
      end
    end
    checks++; if ({core_rst, done, busy} !== 3'b010) begin failures++; $display("FAIL basic_release: got core_rst/done/busy %b want 010", {core_rst, done, busy}); end
    // a stray byte in RUN is ignored
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if ({core_rst, done} !== 2'b01 || s_addr.size() != 4) begin failures++; $display("FAIL run_ignore: got core_rst/done %b strobes %0d want 01 4", {core_rst, done}, s_addr.size()); end
  endtask

  task automatic test_garbage();
    pulse_reset();
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_addr.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL garbage_discard: got strobes %0d busy %b want 0 0", s_addr.size(), busy); end
    send_image();
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_addr.size() != 4) begin failures++; $display("FAIL garbage_strobes: got %0d want 4", s_addr.size()); end
    for (int i = 0; i < 4 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== 32'(4 * i) || s_data[i] !== img_words[i]) begin
        failures++;
        $display("FAIL garbage_word%0d: got %h@%h want %h@%h", i, s_data[i], s_addr[i], img_words[i], 32'(4 * i));
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL garbage_done: got %b want 1", done); end
  endtask

  task automatic test_count_zero();
    logic [31:0] w = 32'hDEADBEEF;
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    send_byte(8'hA5);   // reload from RUN
    checks++; if ({core_rst, done, busy} !== 3'b101) begin failures++; $display("FAIL reload_edge: got core_rst/done/busy %b want 101", {core_rst, done, busy}); end
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if ({error, core_rst, busy} !== 3'b110 || s_addr.size() != 0) begin failures++; $display("FAIL count_zero: got error/core_rst/busy %b strobes %0d want 110 0", {error, core_rst, busy}, s_addr.size()); end
    send_byte(8'hA5);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL error_clear: got %b want 0", error); end
    send_byte(8'h01);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send_byte(word_csum(w));
`endif
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_addr.size() != 1 || s_data[0] !== w || s_addr[0] !== 32'h0) begin
      failures++; $display("FAIL recover_word: got %0d strobes first %h want 1 strobe %h@0", s_addr.size(), s_data[0], w);
    end
    checks++; if ({error, done, core_rst} !== 3'b010) begin failures++; $display("FAIL recover_status: got error/done/core_rst %b want 010", {error, done, core_rst}); end
  endtask

  task automatic test_timeout();
    logic [31:0] w = 32'h11223344;
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    rx_valid = 1'b0;
    repeat (TMO - 5) @(negedge clk);
    checks++; if ({error, busy} !== 2'b01) begin failures++; $display("FAIL timeout_early: got error/busy %b want 01", {error, busy}); end
    repeat (10) @(negedge clk);
    checks++; if ({error, busy, core_rst} !== 3'b101 || s_addr.size() != 0) begin failures++; $display("FAIL timeout_error: got error/busy/core_rst %b strobes %0d want 101 0", {error, busy, core_rst}, s_addr.size()); end
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef LOADER_CHECKSUM_EN
    send_byte(word_csum(w));
`endif
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_addr.size() != 1 || s_data[0] !== w) begin
      failures++; $display("FAIL timeout_restart: got %0d strobes first %h want 1 strobe %h", s_addr.size(), s_data[0], w);
    end
    checks++; if ({error, done} !== 2'b01) begin failures++; $display("FAIL timeout_recover: got error/done %b want 01", {error, done}); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    s_rdy_bad = 0;
    send_image();     // rx_valid never drops between bytes
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_addr.size() != 4) begin failures++; $display("FAIL b2b_strobes: got %0d want 4", s_addr.size()); end
    for (int i = 0; i < 4 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== 32'(4 * i) || s_data[i] !== img_words[i]) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h@%h want %h@%h", i, s_data[i], s_addr[i], img_words[i], 32'(4 * i));
      end
    end
    for (int i = 0; i + 1 < s_cyc.size(); i++) begin
      checks++;
      if (s_cyc[i + 1] - s_cyc[i] != 5) begin failures++; $display("FAIL b2b_spacing%0d: got %0d want 5", i, s_cyc[i + 1] - s_cyc[i]); end
    end
    checks++; if (s_rdy_bad != 0) begin failures++; $display("FAIL b2b_ready_in_write: got %0d strobes with rx_ready=1 want 0", s_rdy_bad); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", done); end
  endtask

  task automatic test_reset_mid_data();
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h13); send_byte(8'h81);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({core_rst, busy, done, error, dbg_wr_en} !== 5'b10000) begin failures++; $display("FAIL async_reset_status: got %b want 10000", {core_rst, busy, done, error, dbg_wr_en}); end
    checks++; if (dbg_addr !== 32'h0 || dbg_instr !== 32'h0) begin failures++; $display("FAIL async_reset_regs: got %h/%h want 0/0", dbg_addr, dbg_instr); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    send_image();
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_addr.size() != 4) begin failures++; $display("FAIL fresh_strobes: got %0d want 4", s_addr.size()); end
    for (int i = 0; i < 4 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== 32'(4 * i) || s_data[i] !== img_words[i]) begin
        failures++;
        $display("FAIL fresh_word%0d: got %h@%h want %h@%h", i, s_data[i], s_addr[i], img_words[i], 32'(4 * i));
      end
    end
    checks++; if ({done, core_rst} !== 2'b10) begin failures++; $display("FAIL fresh_release: got done/core_rst %b want 10", {done, core_rst}); end
`ifdef LOADER_CHECKSUM_EN
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    for (int i = 0; i < 18; i++) send_byte(img[i]);
    send_byte(img_csum() ^ 8'hFF);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({error, core_rst, done} !== 3'b110) begin failures++; $display("FAIL bad_csum: got error/core_rst/done %b want 110", {error, core_rst, done}); end
    checks++; if (s_addr.size() != 4) begin failures++; $display("FAIL bad_csum_strobes: got %0d want 4", s_addr.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_garbage();
    test_count_zero();
    test_timeout();
    test_back_to_back();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
